// File: rtl/param_register_file_if.sv
// Write/read bus of param_register_file: one write port, two read ports, decoded write strobes.
// Pure signal bundle, no logic; the design side uses the slave modport.
// No flow control: every read request and write is accepted in the cycle it is presented.
interface param_register_file_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic                  we;
    logic [ADDR_WIDTH-1:0] Addr;
    logic [DATA_WIDTH-1:0] wData;
    logic                  reA;
    logic                  reB;
    logic [ADDR_WIDTH-1:0] rAddrA;
    logic [ADDR_WIDTH-1:0] rAddrB;
    logic [DATA_WIDTH-1:0] rDataA;
    logic [DATA_WIDTH-1:0] rDataB;
    logic                  rValidA;
    logic                  rValidB;
    logic [DEPTH-1:0]      to_reg;

    modport master (
        output we, Addr, wData, reA, reB, rAddrA, rAddrB,
        input  rDataA, rDataB, rValidA, rValidB, to_reg
    );

    modport slave (
        input  we, Addr, wData, reA, reB, rAddrA, rAddrB,
        output rDataA, rDataB, rValidA, rValidB, to_reg
    );
endinterface

// File: rtl/param_register_file.sv
// Register file, 1 write + 2 registered read ports with write-first bypass; REG0_ZERO_EN ties register 0 to zero.
// Latency: write visible next edge (same edge via bypass); read data/valid 1 cycle after the sampling edge.
// Backpressure: none; reads and writes are always accepted, rValid strobes mark each returned word.
module param_register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    param_register_file_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      dec;

    // The decoded strobe doubles as the bypass condition, so a suppressed
    // register-0 write also suppresses the register-0 bypass.
    always_comb begin
        dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dec[i] = bus.we && (bus.Addr == ADDR_WIDTH'(i));
        end
`ifdef REG0_ZERO_EN
        dec[0] = 1'b0;
`endif
    end

    assign bus.to_reg = dec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dec[i]) begin
                    regs[i] <= bus.wData;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rDataA  <= '0;
            bus.rValidA <= 1'b0;
        end else begin
            bus.rValidA <= bus.reA;
            if (bus.reA) begin
                bus.rDataA <= dec[bus.rAddrA] ? bus.wData : regs[bus.rAddrA];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rDataB  <= '0;
            bus.rValidB <= 1'b0;
        end else begin
            bus.rValidB <= bus.reB;
            if (bus.reB) begin
                bus.rDataB <= dec[bus.rAddrB] ? bus.wData : regs[bus.rAddrB];
            end
        end
    end
endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: stimulus queues expected read data, a negedge monitor pops and compares.
module tb_param_register_file;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    param_register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    param_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 1'b0; bus.Addr = '0; bus.wData = '0;
        bus.reA = 1'b0; bus.rAddrA = '0;
        bus.reB = 1'b0; bus.rAddrB = '0;
    endtask

    // Monitor: every valid strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.rValidA === 1'b1) begin
                if (exp_a.size() == 0) chk("rdA_unexpected_valid", 32'(bus.rValidA), 32'd0);
                else chk("rdA_data", 32'(bus.rDataA), 32'(exp_a.pop_front()));
            end
            if (bus.rValidB === 1'b1) begin
                if (exp_b.size() == 0) chk("rdB_unexpected_valid", 32'(bus.rValidB), 32'd0);
                else chk("rdB_data", 32'(bus.rDataB), 32'(exp_b.pop_front()));
            end
        end
    end

    logic [7:0] to_reg_seq [9];
    logic [2:0] addr_seq   [9];
    logic [7:0] fill_exp0;
    logic [7:0] zero_wr_exp;
    logic [7:0] zero_dec_exp;

    initial begin
        addr_seq   = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd5, 3'd6, 3'd1, 3'd7};
        to_reg_seq = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h20, 8'h40, 8'h02, 8'h80};
`ifdef REG0_ZERO_EN
        fill_exp0    = 8'h00;
        zero_wr_exp  = 8'h00;
        zero_dec_exp = 8'h00;
`else
        fill_exp0    = 8'h10;
        zero_wr_exp  = 8'hFF;
        zero_dec_exp = 8'h01;
`endif
        idle();
        reset = 1'b0;
        #1 reset = 1'b1;
        step();
        step();
        chk("rst_rDataA", 32'(bus.rDataA), 32'd0);
        chk("rst_rDataB", 32'(bus.rDataB), 32'd0);
        chk("rst_rValidA", 32'(bus.rValidA), 32'd0);
        chk("rst_rValidB", 32'(bus.rValidB), 32'd0);
        reset = 1'b0;

        // Decoder: combinational, checked between edges.
        bus.Addr = 3'd5;
        #1 chk("to_reg_we0", 32'(bus.to_reg), 32'h00);
        bus.we = 1'b1;
        bus.wData = 8'h00;
        for (int i = 0; i < 9; i++) begin
            bus.Addr = addr_seq[i];
            #1 chk($sformatf("to_reg_addr%0d", addr_seq[i]), 32'(bus.to_reg), 32'(to_reg_seq[i]));
        end
        step();
        idle();

        // Write then read next cycle, then read data must hold with valid low.
        bus.we = 1'b1; bus.Addr = 3'd3; bus.wData = 8'hA5;
        step();
        idle();
        bus.reA = 1'b1; bus.rAddrA = 3'd3; exp_a.push_back(8'hA5);
        step();
        idle();
        step();
        chk("holdA_rValidA", 32'(bus.rValidA), 32'd0);
        chk("holdA_rDataA", 32'(bus.rDataA), 32'hA5);

        // Bypass on A, old contents on B.
        bus.we = 1'b1; bus.Addr = 3'd2; bus.wData = 8'h11;
        step();
        bus.we = 1'b1; bus.Addr = 3'd6; bus.wData = 8'h3C;
        bus.reA = 1'b1; bus.rAddrA = 3'd6; exp_a.push_back(8'h3C);
        bus.reB = 1'b1; bus.rAddrB = 3'd2; exp_b.push_back(8'h11);
        step();
        idle();
        step();

        // Fill, then back-to-back reads in opposite orders.
        for (int i = 0; i < 8; i++) begin
            bus.we = 1'b1; bus.Addr = 3'(i); bus.wData = 8'(8'h10 + i);
            step();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            bus.reA = 1'b1; bus.rAddrA = 3'(i);
            bus.reB = 1'b1; bus.rAddrB = 3'(7 - i);
            exp_a.push_back(i == 0 ? fill_exp0 : 8'(8'h10 + i));
            exp_b.push_back(i == 7 ? fill_exp0 : 8'(8'h17 - i));
            step();
            if (i > 0) begin
                chk("b2b_rValidA", 32'(bus.rValidA), 32'd1);
                chk("b2b_rValidB", 32'(bus.rValidB), 32'd1);
            end
        end
        idle();
        step();

        // Async reset between edges while a read result is valid.
        bus.reA = 1'b1; bus.rAddrA = 3'd5;
        bus.reB = 1'b1; bus.rAddrB = 3'd6;
        step();
        #1 chk("pre_rst_rValidA", 32'(bus.rValidA), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_rDataA", 32'(bus.rDataA), 32'd0);
        chk("async_rst_rDataB", 32'(bus.rDataB), 32'd0);
        chk("async_rst_rValidA", 32'(bus.rValidA), 32'd0);
        chk("async_rst_rValidB", 32'(bus.rValidB), 32'd0);
        idle();
        step();
        step();
        reset = 1'b0;
        bus.reA = 1'b1; bus.rAddrA = 3'd4; exp_a.push_back(8'h00);
        bus.reB = 1'b1; bus.rAddrB = 3'd4; exp_b.push_back(8'h00);
        step();
        idle();
        step();

        // Write to address 0 while both ports read it.
        bus.we = 1'b1; bus.Addr = 3'd0; bus.wData = 8'hFF;
        bus.reA = 1'b1; bus.rAddrA = 3'd0; exp_a.push_back(zero_wr_exp);
        bus.reB = 1'b1; bus.rAddrB = 3'd0; exp_b.push_back(zero_wr_exp);
        #1 chk("to_reg_addr0", 32'(bus.to_reg), 32'(zero_dec_exp));
        step();
        idle();
        step();
        bus.reA = 1'b1; bus.rAddrA = 3'd0; exp_a.push_back(zero_wr_exp);
        step();
        idle();
        step();
        step();

        chk("queueA_drained", 32'(exp_a.size()), 32'd0);
        chk("queueB_drained", 32'(exp_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised register file with one synchronous write port and two registered read ports. It generalises the 8-entry, 3-bit-address write decoder to a configurable width and depth. It adds write-to-read bypass and read-valid strobes. It sits between the datapath control and the ALU operand registers, and is the storage block the shifter/counter datapath reads operands from.

## Interface
- `DATA_WIDTH`, default 8: bits per register.
- `ADDR_WIDTH`, default 3: address bits. `DEPTH = 2**ADDR_WIDTH` registers.

- `clk`  in  1: single clock; everything is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `we`  in  1: write enable.
- `Addr`  in  ADDR_WIDTH: write address.
- `wData`  in  DATA_WIDTH: write data.
- `reA`, `reB`  in  1: read enable, ports A/B.
- `rAddrA`, `rAddrB`  in  ADDR_WIDTH: read addresses.
- `rDataA`, `rDataB`  out  DATA_WIDTH: registered read data.
- `rValidA`, `rValidB`  out  1: read data valid strobe, one cycle wide.
- `to_reg`  out  DEPTH: one-hot decoded write enable, combinational.

## Operation
- Reset (async, on `reset`=1): all DEPTH registers cleared to 0. `rDataA`/`rDataB` are 0 and `rValidA`/`rValidB` are 0. `to_reg` still follows `we`/`Addr` combinationally.
- Decoder: `to_reg[i] = we && (Addr == i)`. It is all-zero when `we`=0 and never has more than one bit set.
- Write: on each rising edge with `we`=1 and `reset`=0, `reg[Addr] <= wData`. When `we`=0, no register changes.
- Read port A: on a rising edge with `reA`=1:
  - If `we`=1 and `Addr`==`rAddrA`, the bypass applies: `rDataA <= wData`.
  - Otherwise `rDataA <= reg[rAddrA]`.
  - `rValidA <= 1` in both cases.
- Read port A with `reA`=0: `rDataA` holds its previous value and `rValidA <= 0`.
- Port B behaves identically and independently. Both ports may read the same address in the same cycle; both return the same value.
- Address width is exact: all 2**ADDR_WIDTH addresses are legal and there is no out-of-range case.
- Data is stored unmodified. There is no arithmetic and no sign handling.

## Timing
- Write latency: data is visible to a read issued on the following edge, and on the same edge through the bypass.
- Read latency: exactly 1 cycle. Data and valid appear after the edge that sampled `reA`/`rAddrA`.
- Back-to-back reads: one result per cycle per port; `rValidA` stays high continuously.
- Simultaneous write and read of the same address: the read returns the new `wData` (write-first).
- Simultaneous write and read of different addresses: the read returns the old contents.
- Reset asserted mid-operation: the effect is immediate (async). A write on the same edge as reset is discarded. The first valid read after release needs `reset`=0 at the sampling edge.
- Reset release is synchronous in effect: the first edge with `reset`=0 performs normal operation.

## Configuration
- `REG0_ZERO_EN` defined:
  - Register 0 is hard-wired to zero and writes to address 0 are ignored.
  - `to_reg[0]` is forced to 0.
  - Reads of address 0 return 0, including when a bypass write to address 0 occurs in the same cycle.
- `REG0_ZERO_EN` undefined: register 0 is an ordinary register, identical to all others.

## Test plan
All scenarios use `DATA_WIDTH`=8 and `ADDR_WIDTH`=3.
- Reset, then `we`=0 with `Addr`=5: `to_reg`=8'h00. Set `we`=1 and step `Addr` through 5, 4, 3, 2, 1, 5, 6, 1, 7: `to_reg` = 8'h20, 10, 08, 04, 02, 20, 40, 02, 80, each combinationally.
- Write 8'hA5 to address 3. Next cycle, `reA`=1 with `rAddrA`=3: one cycle later `rDataA`=8'hA5 and `rValidA`=1. With `reA`=0 the cycle after, `rValidA`=0 and `rDataA` still reads 8'hA5.
- In one cycle, write 8'h3C to address 6 while `reA`=1/`rAddrA`=6 and `reB`=1/`rAddrB`=2 (register 2 holds 8'h11). Next cycle: `rDataA`=8'h3C (bypass), `rDataB`=8'h11, and both valids are 1.
- Fill all 8 registers with 8'h10+i. Read A in the order 0..7 and B in the order 7..0, back-to-back. Each cycle `rDataA`=8'h10+i and `rDataB`=8'h17-i, with both valids held high for 8 cycles.
- Assert `reset` asynchronously between edges after the registers are filled. `rDataA`, `rDataB`, `rValidA` and `rValidB` go to 0 immediately. After release, reading address 4 returns 8'h00.
- With `REG0_ZERO_EN` defined, write 8'hFF to address 0 while reading it on both ports: `to_reg`=8'h00, `rDataA`=`rDataB`=8'h00. A later read of address 0 also returns 8'h00.
